// File: rtl/arb_pkg.sv
// Shared types and helpers for the N-way priority arbiter.
// Holds the FSM state enum, a clog2 and the pointer wrap-decrement.
package arb_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } arb_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 7; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int wrap_dec(input int k, input int n);
    return (k == 0) ? n - 1 : k - 1;
  endfunction

endpackage

// File: rtl/prio_enc_core.sv
// Combinational N-to-W encoder: index of the highest set bit.
// o_any flags that at least one input bit is set.
module prio_enc_core #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] i_req,
  output logic [W-1:0] o_idx,
  output logic         o_any
);

  always_comb begin
    o_idx = '0;
    o_any = |i_req;
    for (int i = 0; i < N; i++) begin
      if (i_req[i]) o_idx = W'(i);
    end
  end

endmodule

// File: rtl/priority_arbiter_n.sv
// N-way arbiter, fixed or round-robin priority, held grants.
// One idle cycle always separates consecutive grants.
module priority_arbiter_n
  import arb_pkg::*;
#(
  parameter int N = 8,
  parameter int W = clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_in,
  input  logic         mode_rr,
  input  logic         release_in,
  output logic         grant_valid,
  output logic [W-1:0] grant_idx,
  output logic [N-1:0] grant_onehot,
  output logic         none_flag
);

  arb_state_e r_state;
  arb_state_e w_nxt_state;
  logic         r_valid;
  logic         w_nxt_valid;
  logic [W-1:0] r_idx;
  logic [W-1:0] w_nxt_idx;
  logic [N-1:0] r_oh;
  logic [N-1:0] w_nxt_oh;
  logic [W-1:0] r_ptr;
  logic [W-1:0] w_nxt_ptr;
  logic         r_none;

  logic [N-1:0] w_mask;
  logic [N-1:0] w_req_m;
  logic [W-1:0] w_m_idx;
  logic         w_m_any;
  logic [W-1:0] w_u_idx;
  logic         w_u_any;
  logic [W-1:0] w_win;
  logic [N-1:0] w_win_oh;
  logic         w_hold;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < N; i++) begin
      w_mask[i] = (i <= int'(r_ptr));
    end
  end

  assign w_req_m = req_in & w_mask;

  prio_enc_core #(.N(N), .W(W)) u_enc_m (
    .i_req (w_req_m),
    .o_idx (w_m_idx),
    .o_any (w_m_any)
  );

  prio_enc_core #(.N(N), .W(W)) u_enc_u (
    .i_req (req_in),
    .o_idx (w_u_idx),
    .o_any (w_u_any)
  );

  // Masked search wins in RR so the order wraps below P.
  assign w_win  = (mode_rr && w_m_any) ? w_m_idx : w_u_idx;
  assign w_hold = |(req_in & r_oh);

  always_comb begin
    w_win_oh = '0;
    w_win_oh[w_win] = 1'b1;
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_valid = r_valid;
    w_nxt_idx   = r_idx;
    w_nxt_oh    = r_oh;
    w_nxt_ptr   = r_ptr;
    unique case (r_state)
      S_IDLE: begin
        if (w_u_any) begin
          w_nxt_state = S_GRANT;
          w_nxt_valid = 1'b1;
          w_nxt_idx   = w_win;
          w_nxt_oh    = w_win_oh;
          w_nxt_ptr   = W'(wrap_dec(int'(w_win), N));
        end else begin
          w_nxt_valid = 1'b0;
          w_nxt_oh    = '0;
        end
      end
      S_GRANT: begin
        if (release_in || !w_hold) begin
          w_nxt_state = S_IDLE;
          w_nxt_valid = 1'b0;
          w_nxt_oh    = '0;
        end
      end
      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_valid = 1'b0;
        w_nxt_oh    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_oh    <= '0;
      r_ptr   <= W'(N - 1);
      r_none  <= 1'b1;
    end else begin
      r_state <= w_nxt_state;
      r_valid <= w_nxt_valid;
      r_idx   <= w_nxt_idx;
      r_oh    <= w_nxt_oh;
      r_ptr   <= w_nxt_ptr;
      r_none  <= ~|req_in;
    end
  end

  assign grant_valid  = r_valid;
  assign grant_idx    = r_idx;
  assign grant_onehot = r_oh;
  assign none_flag    = r_none;

endmodule

// File: tb/tb_priority_arbiter_n.sv
// Bench for priority_arbiter_n: N=8 vector table plus RR sweep,
// and an N=5 instance for non-power-of-two wrap.
module tb_priority_arbiter_n;

  typedef struct {
    logic        rst;
    logic [7:0]  req;
    logic        rr;
    logic        rel;
    logic        v;
    logic [2:0]  idx;
    logic [7:0]  oh;
    logic        none;
    logic        chkp;
    logic [2:0]  ptr;
  } vec_t;

  typedef struct {
    logic        v;
    logic [5:0]  idx;
    logic [63:0] oh;
    logic        none;
  } exp_t;

  logic       clk;
  logic       rst8, rr8, rel8;
  logic [7:0] req8;
  logic       gv8, none8;
  logic [2:0] gi8;
  logic [7:0] go8;

  logic       rst5, rr5, rel5;
  logic [4:0] req5;
  logic       gv5, none5;
  logic [2:0] gi5;
  logic [4:0] go5;

  int n_tests;
  int n_fail;
  exp_t q8[$];
  exp_t q5[$];
  vec_t tbl[$];

  priority_arbiter_n #(.N(8)) dut8 (
    .clk          (clk),
    .rst          (rst8),
    .req_in       (req8),
    .mode_rr      (rr8),
    .release_in   (rel8),
    .grant_valid  (gv8),
    .grant_idx    (gi8),
    .grant_onehot (go8),
    .none_flag    (none8)
  );

  priority_arbiter_n #(.N(5)) dut5 (
    .clk          (clk),
    .rst          (rst5),
    .req_in       (req5),
    .mode_rr      (rr5),
    .release_in   (rel5),
    .grant_valid  (gv5),
    .grant_idx    (gi5),
    .grant_onehot (go5),
    .none_flag    (none5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [7:0] q,
                              input logic m, input logic l,
                              input logic v, input logic [2:0] i,
                              input logic [7:0] o, input logic n,
                              input logic cp, input logic [2:0] p);
    vec_t t;
    t.rst = r; t.req = q; t.rr = m; t.rel = l;
    t.v = v; t.idx = i; t.oh = o; t.none = n;
    t.chkp = cp; t.ptr = p;
    return t;
  endfunction

  function automatic exp_t ex(input logic v, input int i,
                              input logic [63:0] o, input logic n);
    exp_t e;
    e.v = v; e.idx = 6'(i); e.oh = o; e.none = n;
    return e;
  endfunction

  task automatic step8(input string nm, input logic r,
                       input logic [7:0] q, input logic m,
                       input logic l, input exp_t e);
    exp_t g;
    rst8 = r; req8 = q; rr8 = m; rel8 = l;
    q8.push_back(e);
    @(posedge clk);
    #1;
    g = q8.pop_front();
    chk({nm, " valid"}, 64'(gv8), 64'(g.v));
    chk({nm, " idx"}, 64'(gi8), 64'(g.idx));
    chk({nm, " onehot"}, 64'(go8), g.oh);
    chk({nm, " none"}, 64'(none8), 64'(g.none));
  endtask

  task automatic step5(input string nm, input logic r,
                       input logic [4:0] q, input logic m,
                       input logic l, input exp_t e);
    exp_t g;
    rst5 = r; req5 = q; rr5 = m; rel5 = l;
    q5.push_back(e);
    @(posedge clk);
    #1;
    g = q5.pop_front();
    chk({nm, " valid"}, 64'(gv5), 64'(g.v));
    chk({nm, " idx"}, 64'(gi5), 64'(g.idx));
    chk({nm, " onehot"}, 64'(go5), g.oh);
    chk({nm, " none"}, 64'(none5), 64'(g.none));
    chk({nm, " idx<5"}, 64'(gi5 < 3'd5), 64'd1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst8 = 1'b1; req8 = '0; rr8 = 1'b0; rel8 = 1'b0;
    rst5 = 1'b1; req5 = '0; rr5 = 1'b0; rel5 = 1'b0;

    //            rst req    rr rel  v idx oh     none chkp ptr
    tbl.push_back(mk(1, 8'h00, 0, 0, 0, 0, 8'h00, 1, 1, 7));
    tbl.push_back(mk(1, 8'hFF, 0, 0, 0, 0, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 8'h06, 0, 0, 1, 2, 8'h04, 0, 1, 1));
    tbl.push_back(mk(0, 8'h06, 0, 0, 1, 2, 8'h04, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 2, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 2, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 8'h24, 0, 0, 1, 5, 8'h20, 0, 0, 0));
    tbl.push_back(mk(0, 8'hFF, 0, 0, 1, 5, 8'h20, 0, 0, 0));
    tbl.push_back(mk(0, 8'hFF, 1, 0, 1, 5, 8'h20, 0, 0, 0));
    tbl.push_back(mk(0, 8'hFF, 1, 1, 0, 5, 8'h00, 0, 1, 4));
    tbl.push_back(mk(0, 8'hFF, 1, 0, 1, 4, 8'h10, 0, 1, 3));
    tbl.push_back(mk(0, 8'hFF, 1, 1, 0, 4, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 8'h88, 1, 0, 1, 3, 8'h08, 0, 0, 0));
    tbl.push_back(mk(0, 8'h80, 1, 0, 0, 3, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 8'h80, 1, 0, 1, 7, 8'h80, 0, 1, 6));
    tbl.push_back(mk(0, 8'h81, 1, 1, 0, 7, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 8'h81, 1, 0, 1, 0, 8'h01, 0, 1, 7));
    tbl.push_back(mk(1, 8'h81, 1, 0, 0, 0, 8'h00, 1, 1, 7));
    tbl.push_back(mk(0, 8'h81, 1, 0, 1, 7, 8'h80, 0, 0, 0));
    tbl.push_back(mk(0, 8'h81, 1, 1, 0, 7, 8'h00, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      step8($sformatf("vec%0d", i), tbl[i].rst, tbl[i].req,
            tbl[i].rr, tbl[i].rel,
            ex(tbl[i].v, int'(tbl[i].idx), 64'(tbl[i].oh),
               tbl[i].none));
      if (tbl[i].chkp)
        chk($sformatf("vec%0d ptr", i), 64'(dut8.r_ptr),
            64'(tbl[i].ptr));
    end

    step8("rr rst", 1, 8'hFF, 1, 0, ex(0, 0, 64'h0, 1));
    for (int k = 0; k < 9; k++) begin
      int e;
      e = (15 - k) % 8;
      step8($sformatf("rr g%0d", k), 0, 8'hFF, 1, 0,
            ex(1, e, 64'd1 << e, 0));
      step8($sformatf("rr idle%0d", k), 0, 8'hFF, 1, 1,
            ex(0, e, 64'h0, 0));
    end

    step5("n5 rst", 1, 5'b00000, 0, 0, ex(0, 0, 64'h0, 1));
    chk("n5 rst ptr", 64'(dut5.r_ptr), 64'd4);
    step5("n5 g0", 0, 5'b00001, 1, 0, ex(1, 0, 64'h01, 0));
    chk("n5 wrap ptr", 64'(dut5.r_ptr), 64'd4);
    step5("n5 rel0", 0, 5'b10001, 1, 1, ex(0, 0, 64'h0, 0));
    step5("n5 g4", 0, 5'b10001, 1, 0, ex(1, 4, 64'h10, 0));
    step5("n5 rel4", 0, 5'b10001, 1, 1, ex(0, 4, 64'h0, 0));
    step5("n5 fix", 0, 5'b11111, 0, 0, ex(1, 4, 64'h10, 0));
    step5("n5 rel", 0, 5'b11111, 0, 1, ex(0, 4, 64'h0, 0));
    step5("n5 rr3", 0, 5'b11111, 1, 0, ex(1, 3, 64'h08, 0));
    step5("n5 drop", 0, 5'b00000, 1, 0, ex(0, 3, 64'h0, 1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
